bg_seq_ctrl: RTL
================

Name: bg_seq_ctrl

Overview:
- Parametrised successor to the switched-capacitor bandgap sequencer.
- Generates the non-overlapping switch phases for the precharge, diode, big-diode, high/low charge and output phases, plus the comparator chopping clocks.
- Replaces the fixed src/snk bias nudging with a saturating TRIM_W-bit bias trim calibration loop. Lock is declared on comparator reversals.
- Adds enable, recalibration request, settle-gated valid, and calibration timeout error.
- Sits between the analog bandgap/comparator macro and the chip control logic.

Parameters:
PRE_LEN, 40, precharge phase length in cycles (>=2)
DIODE_LEN, 6, diode phase length in cycles (>=2)
BIG_LEN, 15, big-diode phase length in cycles (>=2)
CHG_LEN, 6, H/L charge phase length in cycles (>=2)
OUT_LEN, 3, output phase length in cycles (>=1)
TRIM_W, 5, bias trim width in bits
TRIM_INIT, 16, trim value loaded at reset and on recal
LOCK_REV, 3, comparator direction reversals required for lock (>=1)
CAL_MAX, 63, max calibration iterations before err
SETTLE_CYC, 12, output phases completed after lock before valid

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
en  input  1  sequencer enable
cmp  input  1  comparator decision, sampled on the last cycle of a phase
recal  input  1  single-cycle recalibration request
PI1, PI2, PII1, PII2  output  1 each  big-diode / diode phase switches
PA, PB, PC, PD  output  1 each  charge/output capacitor switches
s_BG2CMP  output  1  bandgap-to-comparator connect
cmp_p1, cmp_p2  output  1 each  comparator chop phases; cmp_p2 = ~cmp_p1 always
preChrg  output  1  precharge active
setupBias  output  1  bias setup active (high until locked)
trim  output  TRIM_W  bias trim code
locked  output  1  calibration converged
valid  output  1  bandgap output valid
err  output  1  calibration timeout (sticky until recal/reset/en low)

Behaviour:
- Reset (async assert, sync release) and en=0 (synchronous) both force the same state:
  - state IDLE; all P*, s_BG2CMP, preChrg, setupBias, locked, valid and err = 0.
  - cmp_p1 = 1; trim = TRIM_INIT; all counters 0.
- All outputs are registered.
- States: IDLE, PRECHG, BLANK, DIODE, BIGDIODE, HCHG, LCHG, OUTPUT. BLANK holds a 4-bit next-state register.
- IDLE: en=1 enters PRECHG on the next cycle.
- PRECHG, PRE_LEN cycles:
  - preChrg=1, setupBias=1, PB=PC=PD=1, s_BG2CMP=1.
  - cmp_p1 toggles every cycle.
  - Then BLANK -> DIODE.
- BLANK: exactly 1 cycle, all of PI1, PI2, PII1, PII2, PA–PD = 0, preChrg=0. Every transition into DIODE, BIGDIODE, HCHG, LCHG or OUTPUT passes through BLANK.
- DIODE and BIGDIODE phases:
  - DIODE: PII1=1 for all DIODE_LEN cycles; PII2=1 from the 2nd cycle to the last.
  - BIGDIODE: PI1 and PI2 follow the same pattern over BIG_LEN cycles.
  - cmp_p1 toggles on the last DIODE cycle.
- Calibration (locked=0): loop DIODE -> BIGDIODE. On the last BIGDIODE cycle, cmp is sampled:
  - cmp=1: trim decrements, saturating at 0.
  - cmp=0: trim increments, saturating at 2^TRIM_W-1.
  - A direction opposite to the previous iteration's counts one reversal. The first iteration never counts.
  - A saturated step still counts direction.
  - At LOCK_REV reversals: locked=1 and setupBias=0 in the same cycle; enter conversion at DIODE.
  - Hitting CAL_MAX iterations unlocked: err=1, locked=1, trim frozen, conversion proceeds.
- Conversion (locked=1): cycle DIODE -> HCHG -> DIODE -> LCHG -> OUTPUT -> repeat.
  - HCHG: PA=PB=1, s_BG2CMP=1, CHG_LEN cycles.
  - LCHG: PA=PC=1, s_BG2CMP=1, CHG_LEN cycles.
  - OUTPUT: PB=PC=PD=1, PA=0, s_BG2CMP=1, OUT_LEN cycles.
- valid:
  - Rises on the first cycle of the OUTPUT phase that follows SETTLE_CYC completed OUTPUT phases after lock.
  - Stays high thereafter; it is not dropped in non-OUTPUT phases.
- recal=1 in any non-IDLE state:
  - Next cycle: valid=0, locked=0, err=0, setupBias=1, trim=TRIM_INIT, reversal/iteration/settle counters cleared, state BLANK -> DIODE.
  - Precharge is not repeated.
  - recal during a BLANK cycle is handled identically.
- Simultaneous events: en=0 overrides recal; recal overrides lock/err declaration in the same cycle.
- Phase counters are sized $clog2 of the max length + 1; no wrap inside a phase.

Test Plan:
- Reset, en=1, cmp=0 constant, PRE_LEN=40: 40 cycles of preChrg=1 with cmp_p1 toggling; trim climbs 16->31 and saturates; no reversals, so err=1 at iteration 63, locked=1, valid never 1 before 12 OUTPUT phases.
- cmp alternating per BIGDIODE sample (0,1,0,1): trim 16,17,16,17,16; locked=1 after 3rd reversal (4th sample); setupBias falls in the same cycle.
- Locked run: check every phase boundary has exactly one all-zero BLANK cycle, PII2 low on first DIODE cycle, PA/PB in HCHG, PA/PC in LCHG, valid rising at 13th OUTPUT entry.
- recal pulse mid-OUTPUT with valid=1: next cycle valid=0, locked=0, trim=16, setupBias=1, state BLANK then DIODE.
- reset_n asserted mid-HCHG: outputs immediately at reset values asynchronously; en dropped mid-LCHG: IDLE next cycle, all switches 0, cmp_p2=~cmp_p1 throughout.

Source files
------------

// File: rtl/bg_seq_ctrl_if.sv
// Signal bundle between the bandgap sequencer and its analog macro / chip control.
// The sequencer side uses the master modport; the environment uses slave.
interface bg_seq_ctrl_if #(
  parameter int TRIM_W = 5
);
  logic              en;
  logic              cmp;
  logic              recal;
  logic              PI1;
  logic              PI2;
  logic              PII1;
  logic              PII2;
  logic              PA;
  logic              PB;
  logic              PC;
  logic              PD;
  logic              s_BG2CMP;
  logic              cmp_p1;
  logic              cmp_p2;
  logic              preChrg;
  logic              setupBias;
  logic [TRIM_W-1:0] trim;
  logic              locked;
  logic              valid;
  logic              err;

  modport master (
    input  en, cmp, recal,
    output PI1, PI2, PII1, PII2, PA, PB, PC, PD, s_BG2CMP,
    output cmp_p1, cmp_p2, preChrg, setupBias, trim, locked, valid, err
  );

  modport slave (
    output en, cmp, recal,
    input  PI1, PI2, PII1, PII2, PA, PB, PC, PD, s_BG2CMP,
    input  cmp_p1, cmp_p2, preChrg, setupBias, trim, locked, valid, err
  );
endinterface

// File: rtl/bg_seq_ctrl.sv
// Switched-capacitor bandgap sequencer with bias trim calibration.
// States: IDLE off | PRECHG precharge | BLANK 1-cycle gap | DIODE/BIGDIODE diode phases | HCHG/LCHG charge | OUTPUT output
module bg_seq_ctrl #(
  parameter int PRE_LEN    = 40,
  parameter int DIODE_LEN  = 6,
  parameter int BIG_LEN    = 15,
  parameter int CHG_LEN    = 6,
  parameter int OUT_LEN    = 3,
  parameter int TRIM_W     = 5,
  parameter int TRIM_INIT  = 16,
  parameter int LOCK_REV   = 3,
  parameter int CAL_MAX    = 63,
  parameter int SETTLE_CYC = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  bg_seq_ctrl_if.master bus
);
  localparam int M1      = (PRE_LEN > DIODE_LEN) ? PRE_LEN : DIODE_LEN;
  localparam int M2      = (BIG_LEN > CHG_LEN) ? BIG_LEN : CHG_LEN;
  localparam int M3      = (M1 > M2) ? M1 : M2;
  localparam int MAX_LEN = (M3 > OUT_LEN) ? M3 : OUT_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam int IW      = $clog2(CAL_MAX + 1);
  localparam int RW      = $clog2(LOCK_REV + 1);
  localparam int SW      = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [TRIM_W-1:0] TRIM_RST = TRIM_W'(TRIM_INIT);

  typedef enum logic [3:0] {
    S_IDLE, S_PRECHG, S_BLANK, S_DIODE, S_BIGDIODE, S_HCHG, S_LCHG, S_OUTPUT
  } state_t;

  typedef struct packed {
    logic pi1, pi2, pii1, pii2, pa, pb, pc, pd;
    logic s_bg2cmp, pre_chrg, setup_bias, cmp_p1, cmp_p2;
  } sw_t;

  localparam sw_t SW_RST = '{cmp_p1: 1'b1, default: 1'b0};

  state_t            state_q, state_d, nxt_q, nxt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic [RW-1:0]     rev_q, rev_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              dir_q, dir_d, dir_vld_q, dir_vld_d, hl_q, hl_d;
  logic              locked_q, locked_d, err_q, err_d, valid_q, valid_d;
  sw_t               sw_q, sw_d;
  logic              dir_up;

  // Phase timers count down from length-1; zero is the last cycle of the phase.
  function automatic logic [CW-1:0] load_of(state_t s);
    logic [CW-1:0] r;
    r = '0;
    case (s)
      S_PRECHG:   r = CW'(PRE_LEN - 1);
      S_DIODE:    r = CW'(DIODE_LEN - 1);
      S_BIGDIODE: r = CW'(BIG_LEN - 1);
      S_HCHG:     r = CW'(CHG_LEN - 1);
      S_LCHG:     r = CW'(CHG_LEN - 1);
      S_OUTPUT:   r = CW'(OUT_LEN - 1);
      default:    r = '0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      nxt_q     <= S_IDLE;
      cnt_q     <= '0;
      trim_q    <= TRIM_RST;
      iter_q    <= '0;
      rev_q     <= '0;
      settle_q  <= '0;
      dir_q     <= 1'b0;
      dir_vld_q <= 1'b0;
      hl_q      <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      sw_q      <= SW_RST;
    end else begin
      state_q   <= state_d;
      nxt_q     <= nxt_d;
      cnt_q     <= cnt_d;
      trim_q    <= trim_d;
      iter_q    <= iter_d;
      rev_q     <= rev_d;
      settle_q  <= settle_d;
      dir_q     <= dir_d;
      dir_vld_q <= dir_vld_d;
      hl_q      <= hl_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      sw_q      <= sw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    cnt_d     = cnt_q;
    trim_d    = trim_q;
    iter_d    = iter_q;
    rev_d     = rev_q;
    settle_d  = settle_q;
    dir_d     = dir_q;
    dir_vld_d = dir_vld_q;
    hl_d      = hl_q;
    locked_d  = locked_q;
    err_d     = err_q;
    valid_d   = valid_q;
    sw_d      = SW_RST;
    dir_up    = ~bus.cmp;

    if (!bus.en || (bus.recal && state_q != S_IDLE)) begin
      state_d   = bus.en ? S_BLANK : S_IDLE;
      nxt_d     = bus.en ? S_DIODE : S_IDLE;
      cnt_d     = '0;
      trim_d    = TRIM_RST;
      iter_d    = '0;
      rev_d     = '0;
      settle_d  = '0;
      dir_d     = 1'b0;
      dir_vld_d = 1'b0;
      hl_d      = 1'b0;
      locked_d  = 1'b0;
      err_d     = 1'b0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_PRECHG;
          cnt_d   = load_of(S_PRECHG);
        end
        S_BLANK: begin
          state_d = nxt_q;
          cnt_d   = load_of(nxt_q);
          if (nxt_q == S_OUTPUT && settle_q == SW'(SETTLE_CYC)) valid_d = 1'b1;
        end
        default: begin
          if (cnt_q == '0) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            case (state_q)
              S_DIODE: begin
                if (!locked_q) begin
                  nxt_d = S_BIGDIODE;
                end else begin
                  nxt_d = hl_q ? S_LCHG : S_HCHG;
                  hl_d  = ~hl_q;
                end
              end
              S_BIGDIODE: begin
                nxt_d = S_DIODE;
                if (!locked_q) begin
                  if (bus.cmp) begin
                    if (trim_q != '0) trim_d = trim_q - TRIM_W'(1);
                  end else if (trim_q != '1) begin
                    trim_d = trim_q + TRIM_W'(1);
                  end
                  iter_d    = iter_q + IW'(1);
                  dir_d     = dir_up;
                  dir_vld_d = 1'b1;
                  if (dir_vld_q && dir_up != dir_q) rev_d = rev_q + RW'(1);
                  // Lock takes priority over timeout when both land on the same sample.
                  if (rev_d == RW'(LOCK_REV)) begin
                    locked_d = 1'b1;
                    hl_d     = 1'b0;
                    settle_d = '0;
                  end else if (iter_d == IW'(CAL_MAX)) begin
                    locked_d = 1'b1;
                    err_d    = 1'b1;
                    hl_d     = 1'b0;
                    settle_d = '0;
                  end
                end
              end
              S_LCHG:   nxt_d = S_OUTPUT;
              S_OUTPUT: begin
                nxt_d = S_DIODE;
                if (settle_q != SW'(SETTLE_CYC)) settle_d = settle_q + SW'(1);
              end
              default:  nxt_d = S_DIODE;
            endcase
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      endcase
    end

    sw_d.pi1        = (state_d == S_BIGDIODE);
    sw_d.pi2        = (state_d == S_BIGDIODE) && (cnt_d != CW'(BIG_LEN - 1));
    sw_d.pii1       = (state_d == S_DIODE);
    sw_d.pii2       = (state_d == S_DIODE) && (cnt_d != CW'(DIODE_LEN - 1));
    sw_d.pa         = (state_d == S_HCHG) || (state_d == S_LCHG);
    sw_d.pb         = (state_d == S_PRECHG) || (state_d == S_HCHG) || (state_d == S_OUTPUT);
    sw_d.pc         = (state_d == S_PRECHG) || (state_d == S_LCHG) || (state_d == S_OUTPUT);
    sw_d.pd         = (state_d == S_PRECHG) || (state_d == S_OUTPUT);
    sw_d.s_bg2cmp   = sw_d.pb || sw_d.pc;
    sw_d.pre_chrg   = (state_d == S_PRECHG);
    sw_d.setup_bias = (state_d != S_IDLE) && !locked_d;
    if (!bus.en) begin
      sw_d.cmp_p1 = 1'b1;
    end else if (state_d == S_PRECHG || (state_d == S_DIODE && cnt_d == '0)) begin
      sw_d.cmp_p1 = ~sw_q.cmp_p1;
    end else begin
      sw_d.cmp_p1 = sw_q.cmp_p1;
    end
    sw_d.cmp_p2 = ~sw_d.cmp_p1;
  end

  assign bus.PI1       = sw_q.pi1;
  assign bus.PI2       = sw_q.pi2;
  assign bus.PII1      = sw_q.pii1;
  assign bus.PII2      = sw_q.pii2;
  assign bus.PA        = sw_q.pa;
  assign bus.PB        = sw_q.pb;
  assign bus.PC        = sw_q.pc;
  assign bus.PD        = sw_q.pd;
  assign bus.s_BG2CMP  = sw_q.s_bg2cmp;
  assign bus.preChrg   = sw_q.pre_chrg;
  assign bus.setupBias = sw_q.setup_bias;
  assign bus.cmp_p1    = sw_q.cmp_p1;
  assign bus.cmp_p2    = sw_q.cmp_p2;
  assign bus.trim      = trim_q;
  assign bus.locked    = locked_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
endmodule
